// File: rtl/vec_wb_collector.sv
// vec_wb_collector: packs a stream of 32-bit vector elements into one
// register-file write (NUM_ELEM lanes plus lane mask), then holds that write
// on a valid/ready port until the register file takes it. While the write is
// pending, the element stream is stalled.
module vec_wb_collector #(
    parameter int NUM_ELEM = 4,
    parameter int VD_W     = 5
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [31:0]              in_data,
    input  logic [VD_W-1:0]          in_vd,
    input  logic                     in_last,
    output logic                     wr_valid,
    input  logic                     wr_ready,
    output logic [VD_W-1:0]          wr_vd,
    output logic [32*NUM_ELEM-1:0]   wr_data,
    output logic [NUM_ELEM-1:0]      wr_mask
);

    localparam int CNT_W = $clog2(NUM_ELEM);

    typedef enum logic {
        ST_COLLECT = 1'b0,
        ST_FLUSH   = 1'b1
    } state_t;

    state_t                   state_q, state_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [VD_W-1:0]          vd_q, vd_d;
    logic [32*NUM_ELEM-1:0]   data_q, data_d;
    logic [NUM_ELEM-1:0]      mask_q, mask_d;

    logic                     accept;
    logic                     first_slot;
    logic                     last_slot;
    logic [NUM_ELEM-1:0]      lane_sel;

    assign in_ready   = (state_q == ST_COLLECT);
    assign accept     = in_valid & in_ready;
    assign first_slot = (cnt_q == '0);
    assign last_slot  = (cnt_q == CNT_W'(NUM_ELEM - 1));

    // One-hot decode of the lane the next accepted element lands in
    for (genvar gi = 0; gi < NUM_ELEM; gi++) begin : g_lane_sel
        assign lane_sel[gi] = (cnt_q == CNT_W'(gi));
    end

    // Next-state, counter and write-payload logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        vd_d    = vd_q;
        data_d  = data_q;
        mask_d  = mask_q;

        case (state_q)
            ST_COLLECT: begin
                if (accept) begin
                    // A new group starts from a clean slate so unwritten lanes read 0
                    if (first_slot) begin
                        data_d = '0;
                        mask_d = '0;
                        vd_d   = in_vd;
                    end
                    for (int i = 0; i < NUM_ELEM; i++) begin
                        if (lane_sel[i]) begin
                            data_d[32*i +: 32] = in_data;
                            mask_d[i]          = 1'b1;
                        end
                    end
                    if (last_slot || in_last) begin
                        cnt_d   = '0;
                        state_d = ST_FLUSH;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_FLUSH: begin
                // Payload is held; only the handshake moves us back
                if (wr_ready) begin
                    state_d = ST_COLLECT;
                end
            end
            default: begin
                state_d = ST_COLLECT;
                cnt_d   = '0;
            end
        endcase
    end

    // State and payload registers; reset discards any partial or pending write
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_COLLECT;
            cnt_q   <= '0;
            vd_q    <= '0;
            data_q  <= '0;
            mask_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            vd_q    <= vd_d;
            data_q  <= data_d;
            mask_q  <= mask_d;
        end
    end

    assign wr_valid = (state_q == ST_FLUSH);
    assign wr_vd    = vd_q;
    assign wr_data  = data_q;
    assign wr_mask  = mask_q;

endmodule

// File: tb/tb_vec_wb_collector.sv
// Testbench for vec_wb_collector: directed scenarios followed by random
// traffic, all compared every cycle against a group-level reference model.
module tb_vec_wb_collector;

    localparam int N    = 4;
    localparam int VD_W = 5;
    localparam int DW   = 32 * N;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_data;
    logic [VD_W-1:0] in_vd;
    logic            in_last;
    logic            wr_valid;
    logic            wr_ready;
    logic [VD_W-1:0] wr_vd;
    logic [DW-1:0]   wr_data;
    logic [N-1:0]    wr_mask;

    vec_wb_collector #(.NUM_ELEM(N), .VD_W(VD_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_vd    (in_vd),
        .in_last  (in_last),
        .wr_valid (wr_valid),
        .wr_ready (wr_ready),
        .wr_vd    (wr_vd),
        .wr_data  (wr_data),
        .wr_mask  (wr_mask)
    );

    always #5 clk = ~clk;

    int checks_cnt = 0;
    int errors_cnt = 0;
    int writes_cnt = 0;

    // Reference model: elements of the group in progress, plus what the
    // write port is expected to show.
    logic [31:0]     grp_q[$];
    logic [VD_W-1:0] grp_vd;
    bit              pending;
    logic [VD_W-1:0] exp_vd;
    logic [DW-1:0]   exp_data;
    logic [N-1:0]    exp_mask;

    task automatic check_eq(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks_cnt++;
        if (obs !== exp) begin
            errors_cnt++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Rebuild the visible payload from the group collected so far
    task automatic model_show_group();
        exp_vd   = grp_vd;
        exp_data = '0;
        exp_mask = '0;
        foreach (grp_q[i]) begin
            exp_data[32*i +: 32] = grp_q[i];
            exp_mask[i]          = 1'b1;
        end
    endtask

    // One cycle: check outputs from the previous edge, drive new inputs,
    // then advance the model to what the coming edge must produce.
    task automatic step(input bit v, input logic [31:0] d, input logic [VD_W-1:0] vd,
                        input bit last, input bit wrr, input bit r);
        @(negedge clk);
        check_eq("in_ready", DW'(in_ready), DW'(!pending));
        check_eq("wr_valid", DW'(wr_valid), DW'(pending));
        check_eq("wr_vd",    DW'(wr_vd),    DW'(exp_vd));
        check_eq("wr_data",  wr_data,       exp_data);
        check_eq("wr_mask",  DW'(wr_mask),  DW'(exp_mask));

        rst      = r;
        in_valid = v;
        in_data  = d;
        in_vd    = vd;
        in_last  = last;
        wr_ready = wrr;

        if (r) begin
            pending  = 0;
            grp_q.delete();
            exp_vd   = '0;
            exp_data = '0;
            exp_mask = '0;
        end else if (pending) begin
            if (wrr) begin
                pending = 0;
                writes_cnt++;
                $display("WR #%0d vd=%0d mask=%b data=%h", writes_cnt, exp_vd, exp_mask, exp_data);
            end
        end else if (v) begin
            if (grp_q.size() == 0) grp_vd = vd;
            grp_q.push_back(d);
            model_show_group();
            if (grp_q.size() == N || last) begin
                pending = 1;
                grp_q.delete();
            end
        end
    endtask

    task automatic idle(input bit wrr);
        step(0, 32'h0, '0, 0, wrr, 0);
    endtask

    int wr_before;

    initial begin
        pending  = 0;
        grp_vd   = '0;
        exp_vd   = '0;
        exp_data = '0;
        exp_mask = '0;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        in_vd    = '0;
        in_last  = 1'b0;
        wr_ready = 1'b0;
        @(posedge clk);
        step(0, 0, 0, 0, 0, 1);
        idle(0);

        // Full group, register file always ready
        step(1, 32'h11, 5'd3, 0, 1, 0);
        step(1, 32'h22, 5'd3, 0, 1, 0);
        step(1, 32'h33, 5'd3, 0, 1, 0);
        step(1, 32'h44, 5'd3, 0, 1, 0);
        idle(1);
        check_eq("full_valid", DW'(wr_valid), DW'(1));
        check_eq("full_ready", DW'(in_ready), DW'(0));
        check_eq("full_vd",    DW'(wr_vd),    DW'(3));
        check_eq("full_data",  wr_data,       128'h00000044_00000033_00000022_00000011);
        check_eq("full_mask",  DW'(wr_mask),  DW'(4'b1111));
        idle(1);
        check_eq("full_ready_back", DW'(in_ready), DW'(1));

        // Partial group ended by in_last
        step(1, 32'hA, 5'd7, 0, 0, 0);
        step(1, 32'hB, 5'd7, 1, 0, 0);
        idle(0);
        check_eq("part_data", wr_data,      128'h00000000_00000000_0000000B_0000000A);
        check_eq("part_mask", DW'(wr_mask), DW'(4'b0011));
        check_eq("part_vd",   DW'(wr_vd),   DW'(7));
        idle(1);

        // Back-pressure with in_valid held high, then exactly one bubble
        for (int i = 0; i < N; i++) step(1, 32'h100 + i, 5'd5, 0, 0, 0);
        for (int i = 0; i < 5; i++) step(1, 32'h99, 5'd5, 0, 0, 0);
        step(1, 32'h77, 5'd5, 0, 1, 0);
        step(1, 32'h55, 5'd6, 0, 1, 0);
        idle(0);
        check_eq("bp_lane0_data", wr_data,      DW'(32'h55));
        check_eq("bp_lane0_mask", DW'(wr_mask), DW'(4'b0001));
        step(1, 32'h66, 5'd6, 1, 1, 0);
        idle(1);

        // Destination index is taken from the first element only
        step(1, 32'h1, 5'd2, 0, 1, 0);
        step(1, 32'h2, 5'd9, 0, 1, 0);
        step(1, 32'h3, 5'd9, 1, 1, 0);
        idle(1);
        check_eq("vd_sample", DW'(wr_vd), DW'(2));
        idle(1);

        // Reset in the middle of a group
        wr_before = writes_cnt;
        step(1, 32'hDEAD, 5'd1, 0, 1, 0);
        step(1, 32'hBEEF, 5'd1, 0, 1, 0);
        step(0, 0, 0, 0, 1, 1);
        for (int i = 0; i < N; i++) step(1, 32'hC0 + i, 5'd4, 0, 0, 0);
        idle(0);
        check_eq("rstmid_nowrite", DW'(writes_cnt), DW'(wr_before));
        check_eq("rstmid_data", wr_data,      128'h000000C3_000000C2_000000C1_000000C0);
        check_eq("rstmid_mask", DW'(wr_mask), DW'(4'b1111));
        idle(1);

        // Reset while a write is pending and the register file is stalled
        for (int i = 0; i < N; i++) step(1, 32'hE0 + i, 5'd8, 0, 0, 0);
        idle(0);
        wr_before = writes_cnt;
        step(0, 0, 0, 0, 0, 1);
        idle(1);
        check_eq("rstfl_valid", DW'(wr_valid), DW'(0));
        check_eq("rstfl_ready", DW'(in_ready), DW'(1));
        idle(1);
        check_eq("rstfl_nowrite", DW'(writes_cnt), DW'(wr_before));

        // Random traffic
        for (int c = 0; c < 3000; c++) begin
            step($urandom_range(0, 9) < 7,
                 $urandom,
                 VD_W'($urandom),
                 $urandom_range(0, 3) == 0,
                 $urandom_range(0, 1) == 1,
                 $urandom_range(0, 99) == 0);
        end
        step(0, 0, 0, 0, 0, 1);
        idle(0);

        $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
        $finish;
    end

endmodule

// File: doc/vec_wb_collector.md
Name: vec_wb_collector

Overview:
- Downstream consumer of the 32-bit result demux: takes the vector-bound result stream (demux output b, select=1) one 32-bit element at a time.
- Packs the elements into a full vector-register write (NUM_ELEM lanes) with a per-lane write mask.
- Presents that write to the vector register file over a valid/ready handshake.
- Absorbs back-pressure from the register file by stalling the element stream.

Parameters:
- NUM_ELEM, 4, number of 32-bit elements per vector register (power of two, >=2)
- VD_W, 5, width of the destination vector register index

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  element available on in_data
- in_ready  out  1  collector accepts an element this cycle
- in_data  in  32  element value (demux output b)
- in_vd  in  VD_W  destination vector register; sampled on the first element of a group only
- in_last  in  1  this element ends the group (partial vector, vl < NUM_ELEM)
- wr_valid  out  1  packed write pending
- wr_ready  in  1  register file accepts the write
- wr_vd  out  VD_W  destination register of the pending write
- wr_data  out  32*NUM_ELEM  packed lanes; lane i = bits [32*i+31:32*i]
- wr_mask  out  NUM_ELEM  bit i set = lane i written in this group

Behaviour:
Reset (rst=1 at a clk edge):
- State goes to COLLECT; element counter = 0.
- wr_valid = 0, wr_vd = 0, wr_data = 0, wr_mask = 0.
- Reset has priority over every other event. A reset mid-group or mid-flush discards the partial or pending write; no write is issued.

Handshakes:
- An element is accepted when in_valid & in_ready at a clk edge.
- A write completes when wr_valid & wr_ready at a clk edge.

in_ready:
- Combinational: in_ready = (state == COLLECT).
- It does not depend on in_valid or wr_ready.

COLLECT state, on an accepted element with counter value k:
- Lane k of wr_data <= in_data; wr_mask[k] <= 1.
- If k == 0: wr_vd <= in_vd, and all other lanes and mask bits are cleared in the same edge.
- If k == NUM_ELEM-1 or in_last == 1: counter <= 0 and state <= FLUSH.
- Otherwise: counter <= k+1.
- The counter never exceeds NUM_ELEM-1. The NUM_ELEM-th element forces FLUSH regardless of in_last.
- in_vd on a non-first element is ignored.

FLUSH state:
- wr_valid = 1; wr_vd, wr_data and wr_mask are held stable.
- On wr_ready: state <= COLLECT and wr_valid <= 0. Data and mask hold their stale values until overwritten by the next group's first element.
- Back-to-back: no element is accepted in the cycle the write completes. The next element is accepted at the earliest on the following edge, so there is one bubble per group.
- wr_ready high while not in FLUSH has no effect.

Latency and lane rules:
- wr_valid rises on the edge that accepts the final element, so it is visible the cycle after the final input handshake.
- Unwritten lanes of a partial group read 0 with mask bit 0.
- in_last on the first element produces a single-lane write with wr_mask = 0001.

Test Plan:
- Full group: NUM_ELEM=4, in_vd=3, elements 0x11,0x22,0x33,0x44 on consecutive cycles with in_last=0 and wr_ready=1.
  -> in_ready drops after the 4th element; wr_valid=1 with wr_vd=3, wr_data=0x00000044_00000033_00000022_00000011, wr_mask=1111.
  -> Write completes that cycle; in_ready returns the next cycle.
- Partial group: elements 0xA,0xB, in_last on 0xB, in_vd=7.
  -> wr_data = 0,0,0xB,0xA (lanes 3..0), wr_mask=0011, wr_vd=7.
- Back-pressure: hold wr_ready=0 for 5 cycles after a full group while in_valid stays high.
  -> wr_valid and its outputs stay constant and in_ready=0 throughout.
  -> After wr_ready=1, exactly one bubble, then the next element lands in lane 0 with the previous lanes cleared.
- vd sampling: first element in_vd=2, later elements in_vd=9.
  -> wr_vd=2.
- Reset mid-group: after 2 elements accepted, pulse rst for 1 cycle, then send 4 new elements.
  -> No write is issued before the reset; the following write holds only the 4 new elements with wr_mask=1111.
- Reset during FLUSH with wr_ready=0.
  -> wr_valid=0 on the next cycle and in_ready=1; the pending write is never observed with wr_ready high.
